// File: rtl/sim_memory_arbiter_pkg.sv
// Shared requester ids, ORDER encodings and the request record used by the
// two-requester memory port arbiter.
package sim_memory_arbiter_pkg;

  localparam logic RQ0 = 1'b0;
  localparam logic RQ1 = 1'b1;

  typedef enum logic [1:0] {
    ORDER_BYTE = 2'b00,
    ORDER_HALF = 2'b01,
    ORDER_WORD = 2'b10,
    ORDER_NONE = 2'b11
  } order_e;

  typedef struct packed {
    logic [1:0]  order;
    logic [3:0]  mask;
    logic        rw;
    logic [25:0] addr;
    logic [31:0] data;
  } mem_req_t;

endpackage

// File: rtl/mist1032isa_sync_fifo.sv
// Single-clock FIFO with an occupancy counter; a write into a full FIFO is
// accepted when a read retires an entry in the same cycle.
module mist1032isa_sync_fifo #(
  parameter int P_N       = 1,
  parameter int P_DEPTH   = 8,
  parameter int P_DEPTH_N = 3
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iWR_EN,
  input  logic [P_N-1:0]     iWR_DATA,
  output logic               oWR_FULL,
  input  logic               iRD_EN,
  output logic [P_N-1:0]     oRD_DATA,
  output logic               oRD_EMPTY
);

  localparam logic [P_DEPTH_N:0] LP_FULL = (P_DEPTH_N + 1)'(P_DEPTH);

  logic [P_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
  logic [P_DEPTH_N:0]   count_q, count_d;
  logic [P_N-1:0]       mem_q [P_DEPTH];
  logic                 do_wr, do_rd;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    do_rd    = iRD_EN && (count_q != '0);
    do_wr    = iWR_EN && ((count_q != LP_FULL) || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + P_DEPTH_N'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + P_DEPTH_N'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (P_DEPTH_N + 1)'(1);
      2'b01:   count_d = count_q - (P_DEPTH_N + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge iCLOCK) begin
    if (do_wr) mem_q[wr_ptr_q] <= iWR_DATA;
  end

  assign oWR_FULL  = (count_q == LP_FULL);
  assign oRD_EMPTY = (count_q == '0);
  assign oRD_DATA  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sim_memory_port_arbiter.sv
// Two-requester round-robin memory port arbiter with a one-entry request slot
// and an in-order tag FIFO that routes read responses back to their owner.
module sim_memory_port_arbiter
  import sim_memory_arbiter_pkg::*;
#(
  parameter int P_TAG_DEPTH   = 8,
  parameter int P_TAG_DEPTH_N = 3
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRQ0_REQ,
  output logic        oRQ0_LOCK,
  input  logic [1:0]  iRQ0_ORDER,
  input  logic [3:0]  iRQ0_MASK,
  input  logic        iRQ0_RW,
  input  logic [25:0] iRQ0_ADDR,
  input  logic [31:0] iRQ0_DATA,
  output logic        oRQ0_VALID,
  input  logic        iRQ0_LOCK,
  output logic [63:0] oRQ0_DATA,
  input  logic        iRQ1_REQ,
  output logic        oRQ1_LOCK,
  input  logic [1:0]  iRQ1_ORDER,
  input  logic [3:0]  iRQ1_MASK,
  input  logic        iRQ1_RW,
  input  logic [25:0] iRQ1_ADDR,
  input  logic [31:0] iRQ1_DATA,
  output logic        oRQ1_VALID,
  input  logic        iRQ1_LOCK,
  output logic [63:0] oRQ1_DATA,
  output logic        oMEM_REQ,
  output logic [1:0]  oMEM_ORDER,
  output logic [3:0]  oMEM_MASK,
  output logic        oMEM_RW,
  output logic [25:0] oMEM_ADDR,
  output logic [31:0] oMEM_DATA,
  input  logic        iMEM_LOCK,
  input  logic        iMEM_VALID,
  input  logic [63:0] iMEM_DATA,
  output logic        oMEM_LOCK,
  output logic        oERROR
);

  mem_req_t slot_q, slot_d;
  mem_req_t rq0_req, rq1_req;
  logic     slot_valid_q, slot_valid_d;
  logic     last_grant_q, last_grant_d;
  logic     error_q, error_d;

  logic tag_full, tag_empty, tag_head;
  logic tag_push, tag_push_id, tag_pop, tag_room;
  logic head_lock, slot_free;
  logic elig0, elig1, grant0, grant1;
  logic rsp0, rsp1;

  assign rq0_req = {iRQ0_ORDER, iRQ0_MASK, iRQ0_RW, iRQ0_ADDR, iRQ0_DATA};
  assign rq1_req = {iRQ1_ORDER, iRQ1_MASK, iRQ1_RW, iRQ1_ADDR, iRQ1_DATA};

  always_comb begin
    head_lock = (tag_head == RQ1) ? iRQ1_LOCK : iRQ0_LOCK;
    tag_pop   = iMEM_VALID && !tag_empty && !head_lock;
    // A full tag FIFO still admits a read when its head retires this cycle.
    tag_room  = !tag_full || tag_pop;
    slot_free = !slot_valid_q || !iMEM_LOCK;

    elig0  = inRESET && slot_free && iRQ0_REQ && (iRQ0_RW || tag_room);
    elig1  = inRESET && slot_free && iRQ1_REQ && (iRQ1_RW || tag_room);
    grant0 = elig0 && (!elig1 || (last_grant_q == RQ1));
    grant1 = elig1 && !grant0;

    tag_push    = (grant0 && !iRQ0_RW) || (grant1 && !iRQ1_RW);
    tag_push_id = grant1 ? RQ1 : RQ0;

    slot_valid_d = slot_valid_q;
    slot_d       = slot_q;
    last_grant_d = last_grant_q;
    if (slot_free) begin
      slot_valid_d = grant0 || grant1;
      if (grant0)      slot_d = rq0_req;
      else if (grant1) slot_d = rq1_req;
    end
    if (grant0)      last_grant_d = RQ0;
    else if (grant1) last_grant_d = RQ1;

    error_d = error_q || (iMEM_VALID && tag_empty);
  end

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      slot_valid_q <= 1'b0;
      last_grant_q <= RQ1;
      error_q      <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      last_grant_q <= last_grant_d;
      error_q      <= error_d;
    end
  end

  // Payload is only meaningful while slot_valid_q is set.
  always_ff @(posedge iCLOCK) begin
    slot_q <= slot_d;
  end

  mist1032isa_sync_fifo #(
    .P_N       (1),
    .P_DEPTH   (P_TAG_DEPTH),
    .P_DEPTH_N (P_TAG_DEPTH_N)
  ) u_tag_fifo (
    .iCLOCK    (iCLOCK),
    .inRESET   (inRESET),
    .iWR_EN    (tag_push),
    .iWR_DATA  (tag_push_id),
    .oWR_FULL  (tag_full),
    .iRD_EN    (tag_pop),
    .oRD_DATA  (tag_head),
    .oRD_EMPTY (tag_empty)
  );

  assign rsp0 = iMEM_VALID && !tag_empty && (tag_head == RQ0);
  assign rsp1 = iMEM_VALID && !tag_empty && (tag_head == RQ1);

  assign oRQ0_LOCK  = !grant0;
  assign oRQ1_LOCK  = !grant1;
  assign oRQ0_VALID = rsp0;
  assign oRQ1_VALID = rsp1;
  assign oRQ0_DATA  = rsp0 ? iMEM_DATA : '0;
  assign oRQ1_DATA  = rsp1 ? iMEM_DATA : '0;
  assign oMEM_LOCK  = !tag_empty && head_lock;

  assign oMEM_REQ   = slot_valid_q;
  assign oMEM_ORDER = slot_q.order;
  assign oMEM_MASK  = slot_q.mask;
  assign oMEM_RW    = slot_q.rw;
  assign oMEM_ADDR  = slot_q.addr;
  assign oMEM_DATA  = slot_q.data;
  assign oERROR     = error_q;

endmodule

// File: tb/tb_sim_memory_port_arbiter.sv
// Self-checking bench: table of arbitration vectors plus hand-written stall,
// tag-full, response-lock, error and mid-transaction reset sequences.
`timescale 1ns/1ps
module tb_sim_memory_port_arbiter;
  import sim_memory_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_i [2];
  logic        rw_i [2];
  logic        lock_i [2];
  logic [1:0]  order_i [2];
  logic [3:0]  mask_i [2];
  logic [25:0] addr_i [2];
  logic [31:0] wdata_i [2];
  logic        lock_o [2];
  logic        valid_o [2];
  logic [63:0] rdata_o [2];
  logic        mem_req, mem_rw, mem_lock_i, mem_valid, mem_lock_o, error_o;
  logic [1:0]  mem_order;
  logic [3:0]  mem_mask;
  logic [25:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [63:0] mem_rdata;

  sim_memory_port_arbiter dut (
    .iCLOCK(clk), .inRESET(rst_n),
    .iRQ0_REQ(req_i[0]), .oRQ0_LOCK(lock_o[0]), .iRQ0_ORDER(order_i[0]), .iRQ0_MASK(mask_i[0]),
    .iRQ0_RW(rw_i[0]), .iRQ0_ADDR(addr_i[0]), .iRQ0_DATA(wdata_i[0]), .oRQ0_VALID(valid_o[0]),
    .iRQ0_LOCK(lock_i[0]), .oRQ0_DATA(rdata_o[0]),
    .iRQ1_REQ(req_i[1]), .oRQ1_LOCK(lock_o[1]), .iRQ1_ORDER(order_i[1]), .iRQ1_MASK(mask_i[1]),
    .iRQ1_RW(rw_i[1]), .iRQ1_ADDR(addr_i[1]), .iRQ1_DATA(wdata_i[1]), .oRQ1_VALID(valid_o[1]),
    .iRQ1_LOCK(lock_i[1]), .oRQ1_DATA(rdata_o[1]),
    .oMEM_REQ(mem_req), .oMEM_ORDER(mem_order), .oMEM_MASK(mem_mask), .oMEM_RW(mem_rw),
    .oMEM_ADDR(mem_addr), .oMEM_DATA(mem_wdata), .iMEM_LOCK(mem_lock_i),
    .iMEM_VALID(mem_valid), .iMEM_DATA(mem_rdata), .oMEM_LOCK(mem_lock_o), .oERROR(error_o)
  );

  typedef struct packed {
    logic [1:0]  order;
    logic [3:0]  mask;
    logic        rw;
    logic [25:0] addr;
    logic [31:0] data;
  } iss_t;

  typedef struct {
    logic r0; logic w0; logic [25:0] a0;
    logic r1; logic w1; logic [25:0] a1;
    logic g0; logic g1;
  } vec_t;

  iss_t iss_q [$];
  logic resp_q [$];
  logic exp_err;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int n, input logic r, input logic w, input logic [25:0] a);
    req_i[n]   = r;
    rw_i[n]    = w;
    addr_i[n]  = a;
    order_i[n] = a[8] ? ORDER_HALF : ORDER_WORD;
    mask_i[n]  = {a[4:2], 1'b1};
    wdata_i[n] = 32'h5A00_0000 ^ {6'h0, a} ^ 32'(n);
  endtask

  task automatic idle();
    req_i[0] = 1'b0;
    req_i[1] = 1'b0;
  endtask

  task automatic push(input int n);
    iss_q.push_back({order_i[n], mask_i[n], rw_i[n], addr_i[n], wdata_i[n]});
    if (!rw_i[n]) resp_q.push_back(1'(n));
  endtask

  // One clock: compare outputs mid-cycle against the scoreboards, record the
  // requests expected to be accepted, then advance past the edge.
  task automatic cycle(input logic el0, input logic el1);
    logic pre_empty;
    logic id;
    #2;
    check("rq0_lock", lock_o[0], el0);
    check("rq1_lock", lock_o[1], el1);
    pre_empty = (resp_q.size() == 0);
    if (rst_n) begin
      check("mem_req", mem_req, iss_q.size() != 0);
      if (iss_q.size() != 0) begin
        check("issue", {mem_order, mem_mask, mem_rw, mem_addr, mem_wdata}, iss_q[0]);
        if (!mem_lock_i) void'(iss_q.pop_front());
      end
      check("error", error_o, exp_err);
      if (pre_empty) begin
        check("mem_lock_empty", mem_lock_o, 1'b0);
        check("rq0_valid_empty", valid_o[0], 1'b0);
        check("rq1_valid_empty", valid_o[1], 1'b0);
        check("rq0_data_empty", rdata_o[0], 64'h0);
        check("rq1_data_empty", rdata_o[1], 64'h0);
      end else begin
        id = resp_q[0];
        check("mem_lock", mem_lock_o, lock_i[id]);
        check("valid_owner", valid_o[id], mem_valid);
        check("valid_other", valid_o[!id], 1'b0);
        check("data_owner", rdata_o[id], mem_valid ? mem_rdata : 64'h0);
        check("data_other", rdata_o[!id], 64'h0);
        if (mem_valid && !lock_i[id]) void'(resp_q.pop_front());
      end
      if (!el0) push(0);
      if (!el1) push(1);
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      iss_q.delete();
      resp_q.delete();
      exp_err = 1'b0;
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_lock", mem_lock_o, 1'b0);
      check("rst_error", error_o, 1'b0);
      check("rst_rq0_valid", valid_o[0], 1'b0);
      check("rst_rq1_valid", valid_o[1], 1'b0);
    end else if (mem_valid && pre_empty) begin
      exp_err = 1'b1;
    end
  endtask

  task automatic respond(input logic [63:0] d);
    mem_valid = 1'b1;
    mem_rdata = d;
    cycle(1'b1, 1'b1);
    mem_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    vecs[0] = '{1'b1, 1'b0, 26'h100, 1'b1, 1'b0, 26'h200, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 26'h104, 1'b1, 1'b0, 26'h204, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 26'h108, 1'b1, 1'b0, 26'h208, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 26'h10C, 1'b1, 1'b0, 26'h20C, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 26'h010, 1'b0, 1'b0, 26'h000, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 26'h000, 1'b0, 1'b0, 26'h000, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 26'h000, 1'b1, 1'b1, 26'h040, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 26'h044, 1'b1, 1'b1, 26'h048, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 26'h04C, 1'b1, 1'b0, 26'h050, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 26'h000, 1'b1, 1'b1, 26'h054, 1'b0, 1'b1};

    rst_n      = 1'b0;
    mem_lock_i = 1'b0;
    mem_valid  = 1'b0;
    mem_rdata  = '0;
    exp_err    = 1'b0;
    lock_i[0]  = 1'b0;
    lock_i[1]  = 1'b0;
    drive(0, 1'b1, 1'b0, 26'h0);
    drive(1, 1'b1, 1'b1, 26'h0);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    rst_n = 1'b1;
    idle();

    // Round robin from reset, singles, write/read mixes.
    for (int i = 0; i < 10; i++) begin
      drive(0, vecs[i].r0, vecs[i].w0, vecs[i].a0);
      drive(1, vecs[i].r1, vecs[i].w1, vecs[i].a1);
      cycle(!vecs[i].g0, !vecs[i].g1);
    end
    idle();
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) respond(64'h1111_2222_0000_0000 + 64'(i));
    check("table_issue_drained", iss_q.size(), 0);
    check("table_resp_drained", resp_q.size(), 0);

    // Slot held while memory is locked; payload must stay stable.
    mem_lock_i = 1'b1;
    drive(0, 1'b1, 1'b1, 26'h300);
    wdata_i[0] = 32'hA5A5_A5A5;
    cycle(1'b0, 1'b1);
    drive(0, 1'b1, 1'b1, 26'h304);
    drive(1, 1'b1, 1'b1, 26'h308);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    mem_lock_i = 1'b0;
    cycle(1'b1, 1'b0);
    idle();
    cycle(1'b1, 1'b1);

    // Fill the tag FIFO; reads lock out, a write still goes through.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b1, 1'b0, 26'h400 + 26'(4 * i));
      cycle(1'b0, 1'b1);
    end
    drive(0, 1'b0, 1'b0, 26'h0);
    drive(1, 1'b1, 1'b0, 26'h500);
    cycle(1'b1, 1'b1);
    drive(0, 1'b1, 1'b0, 26'h504);
    drive(1, 1'b1, 1'b1, 26'h01C);
    wdata_i[1] = 32'hDEAD_BEEF;
    cycle(1'b1, 1'b0);
    idle();
    cycle(1'b1, 1'b1);
    drive(0, 1'b1, 1'b0, 26'h508);
    mem_valid = 1'b1;
    mem_rdata = 64'hFEED_0000_0000_0001;
    cycle(1'b0, 1'b1);
    mem_valid = 1'b0;
    idle();
    for (int i = 0; i < 8; i++) respond(64'h3333_0000_0000_0000 + 64'(i));
    check("full_resp_drained", resp_q.size(), 0);

    // Response held back by the owning requester.
    drive(1, 1'b1, 1'b0, 26'h600);
    cycle(1'b1, 1'b0);
    idle();
    cycle(1'b1, 1'b1);
    lock_i[1] = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = 64'h0000_0000_0000_BEEF;
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    lock_i[1] = 1'b0;
    cycle(1'b1, 1'b1);
    mem_valid = 1'b0;
    cycle(1'b1, 1'b1);
    check("lock_resp_drained", resp_q.size(), 0);

    // Orphan response: dropped and sticky error.
    mem_valid = 1'b1;
    mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    cycle(1'b1, 1'b1);
    mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    check("error_sticky", error_o, 1'b1);

    // Reset with a request in the slot and a tag outstanding.
    mem_lock_i = 1'b1;
    drive(0, 1'b1, 1'b0, 26'h700);
    cycle(1'b0, 1'b1);
    idle();
    lock_i[0] = 1'b1;
    rst_n = 1'b0;
    cycle(1'b1, 1'b1);
    rst_n = 1'b1;
    lock_i[0] = 1'b0;
    mem_lock_i = 1'b0;
    drive(0, 1'b1, 1'b0, 26'h710);
    drive(1, 1'b1, 1'b0, 26'h720);
    cycle(1'b0, 1'b1);
    idle();
    cycle(1'b1, 1'b1);
    respond(64'h7777_0000_0000_0710);
    check("final_issue_drained", iss_q.size(), 0);
    check("final_resp_drained", resp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
